reception_module: RTL and testbench

RECEPTION_MODULE -- requirements
Module: reception_module

---
 rtl/reception_module.sv | 156 +++++++++++++++
 tb/tb_reception_module.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/reception_module.sv
// reception_module: serial word receiver. Bits arrive MSB first on sda_i and are
// sampled on each rising edge of the asynchronous scl_i while en_i frames the
// transfer. Each completed word is held on data_o until the consumer acks it.
//
// Build option: define RECEPTION_MODULE_SYNC2_EN to use a two-flop synchronizer
// per input (S = 2). The default build uses one register stage (S = 1). The only
// visible difference is that valid_o rises one cycle later.
//
// Ports
//   clk_i      system clock, rising edge
//   reset_i    synchronous active-high reset
//   en_i       line enable, high while a frame is in progress (async)
//   sda_i      serial data, MSB first (async)
//   scl_i      serial clock from the transmitter (async)
//   ack_i      consumer acknowledge of the held word
//   data_o     last completed word
//   valid_o    data_o holds an unacknowledged word
//   busy_o     a frame is being received
//   overrun_o  one-cycle pulse: a completed word was dropped
//   err_o      one-cycle pulse: frame aborted mid-word
module reception_module #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  en_i,
  input  logic                  sda_i,
  input  logic                  scl_i,
  input  logic                  ack_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  output logic                  busy_o,
  output logic                  overrun_o,
  output logic                  err_o
);

  localparam int unsigned CntW = $clog2(DATA_WIDTH) + 1;

`ifdef RECEPTION_MODULE_SYNC2_EN
  localparam int unsigned SyncDepth = 2;
`else
  localparam int unsigned SyncDepth = 1;
`endif

  typedef enum logic [1:0] {StIdle, StRecv, StDone} state_e;

  state_e                state_q, state_d;
  logic [SyncDepth-1:0]  en_sync_q, sda_sync_q, scl_sync_q;
  logic                  scl_dly_q;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  overrun_q, overrun_d;
  logic                  err_q, err_d;

  logic en_s, sda_s, scl_s, scl_rise;

  assign en_s     = en_sync_q[SyncDepth-1];
  assign sda_s    = sda_sync_q[SyncDepth-1];
  assign scl_s    = scl_sync_q[SyncDepth-1];
  // One detection per scl edge, however long scl stays high.
  assign scl_rise = scl_s & ~scl_dly_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      en_sync_q  <= '0;
      sda_sync_q <= '0;
      scl_sync_q <= '0;
      scl_dly_q  <= 1'b0;
      state_q    <= StIdle;
      cnt_q      <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      // Truncating cast keeps the low SyncDepth bits: shift in at bit 0.
      en_sync_q  <= SyncDepth'({en_sync_q, en_i});
      sda_sync_q <= SyncDepth'({sda_sync_q, sda_i});
      scl_sync_q <= SyncDepth'({scl_sync_q, scl_i});
      scl_dly_q  <= scl_s;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      overrun_q  <= overrun_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;
    err_d     = 1'b0;

    if (ack_i && valid_q) begin
      valid_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (en_s) begin
          state_d = StRecv;
          cnt_d   = '0;
          shift_d = '0;
        end
      end
      StRecv: begin
        if (cnt_q == CntW'(DATA_WIDTH)) begin
          // Word complete: it is delivered even if en drops now.
          state_d = StDone;
          cnt_d   = '0;
        end else if (!en_s) begin
          // en falling beats a coincident scl edge; partial bits are dropped.
          state_d = StIdle;
          err_d   = (cnt_q != '0);
          cnt_d   = '0;
          shift_d = '0;
        end else if (scl_rise) begin
          shift_d = DATA_WIDTH'({shift_q, sda_s});
          cnt_d   = cnt_q + 1'b1;
        end
      end
      StDone: begin
        // An ack in this very cycle frees the slot, so the new word is loaded.
        if (!valid_q || ack_i) begin
          data_d  = shift_q;
          valid_d = 1'b1;
        end else begin
          overrun_d = 1'b1;
        end
        if (en_s) begin
          state_d = StRecv;
          shift_d = '0;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign data_o    = data_q;
  assign valid_o   = valid_q;
  assign busy_o    = (state_q == StRecv);
  assign overrun_o = overrun_q;
  assign err_o     = err_q;

endmodule

// File: tb/tb_reception_module.sv
// Bench for reception_module: directed scenarios followed by randomized frames,
// checked against a word-level model of what the consumer should observe.
module tb_reception_module;

`ifdef RECEPTION_MODULE_SYNC2_EN
  localparam int S = 2;
`else
  localparam int S = 1;
`endif
  localparam int DW = 8;

  logic          clk_i = 1'b0;
  logic          reset_i, en_i, sda_i, scl_i, ack_i;
  logic [DW-1:0] data_o;
  logic          valid_o, busy_o, overrun_o, err_o;

  reception_module #(.DATA_WIDTH(DW)) dut (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .en_i      (en_i),
    .sda_i     (sda_i),
    .scl_i     (scl_i),
    .ack_i     (ack_i),
    .data_o    (data_o),
    .valid_o   (valid_o),
    .busy_o    (busy_o),
    .overrun_o (overrun_o),
    .err_o     (err_o)
  );

  always #5 clk_i = ~clk_i;

  int n_vec  = 0;
  int n_miss = 0;

  // Pulse counters observed on the DUT outputs.
  int ovr_seen = 0;
  int err_seen = 0;
  always @(negedge clk_i) begin
    if (overrun_o) ovr_seen++;
    if (err_o) err_seen++;
  end

  // Word-level reference model.
  logic [DW-1:0] exp_data;
  logic          exp_valid;
  int            exp_ovr;
  int            exp_err;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, ".valid"}, valid_o, exp_valid);
    check_eq({tag, ".data"}, data_o, exp_data);
    check_eq({tag, ".ovr"}, ovr_seen, exp_ovr);
    check_eq({tag, ".err"}, err_seen, exp_err);
  endtask

  // ack_mode: 0 none, 1 ack pulse after the word lands, 2 ack in the DONE cycle.
  // end_mode: 0 drop en after the word, 1 keep en (back-to-back), 2 drop en as an
  //           abort after nbits bits, 3 leave the line as is (caller resets).
  task automatic send_frame(input logic [DW-1:0] w, input int nbits, input int ack_mode,
                            input int end_mode);
    if (!en_i) begin
      en_i  = 1'b1;
      scl_i = 1'b0;
      repeat (S + 3) @(negedge clk_i);
    end
    for (int b = 0; b < nbits; b++) begin
      sda_i = w[DW-1-b];
      scl_i = 1'b1;
      for (int j = 1; j <= 8; j++) begin
        @(negedge clk_i);
        if (j == 4) scl_i = 1'b0;
        if (b == 0 && j == 2) check_eq("busy_in_frame", busy_o, 1);
        if (b == DW - 1) begin
          if (j == S + 2) begin
            // One cycle before the word may land: outputs still show the old state.
            check_eq("pre.valid", valid_o, exp_valid);
            check_eq("pre.data", data_o, exp_data);
            if (ack_mode == 2) ack_i = 1'b1;
          end
          if (j == S + 3) begin
            ack_i = 1'b0;
            if (!exp_valid || ack_mode == 2) begin
              exp_data  = w;
              exp_valid = 1'b1;
            end else begin
              exp_ovr++;
            end
            check_eq("post.valid", valid_o, exp_valid);
            check_eq("post.data", data_o, exp_data);
          end
          if (ack_mode == 1 && j == S + 4) ack_i = 1'b1;
          if (ack_mode == 1 && j == S + 5) begin
            ack_i     = 1'b0;
            exp_valid = 1'b0;
          end
          if (ack_mode == 1 && j == S + 6) check_eq("ack.valid", valid_o, 0);
          if (j == 8) check_eq("word.ovr", ovr_seen, exp_ovr);
        end
      end
    end
    if (end_mode == 0) begin
      en_i = 1'b0;
      repeat (S + 3) @(negedge clk_i);
      check_eq("busy_after", busy_o, 0);
      check_all("frame_end");
    end else if (end_mode == 2) begin
      en_i = 1'b0;
      if (nbits > 0 && nbits < DW) exp_err++;
      repeat (S + 4) @(negedge clk_i);
      check_eq("busy_abort", busy_o, 0);
      check_all("abort");
    end
  endtask

  task automatic ack_pulse();
    ack_i = 1'b1;
    @(negedge clk_i);
    ack_i     = 1'b0;
    exp_valid = 1'b0;
    @(negedge clk_i);
    check_eq("idle_ack.valid", valid_o, 0);
    check_eq("idle_ack.data", data_o, exp_data);
  endtask

  task automatic reset_mid_frame(input logic [DW-1:0] w);
    send_frame(w, 3, 0, 3);
    reset_i = 1'b1;
    en_i    = 1'b0;
    scl_i   = 1'b0;
    sda_i   = 1'b0;
    @(negedge clk_i);
    exp_data  = '0;
    exp_valid = 1'b0;
    check_eq("rst.data", data_o, 0);
    check_eq("rst.valid", valid_o, 0);
    check_eq("rst.busy", busy_o, 0);
    check_eq("rst.ovr", overrun_o, 0);
    check_eq("rst.err", err_o, 0);
    reset_i = 1'b0;
    repeat (S + 3) @(negedge clk_i);
    check_all("after_rst");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int op, nb, am, em;
    logic [DW-1:0] w;
    reset_i   = 1'b1;
    en_i      = 1'b0;
    sda_i     = 1'b0;
    scl_i     = 1'b0;
    ack_i     = 1'b0;
    exp_data  = '0;
    exp_valid = 1'b0;
    exp_ovr   = 0;
    exp_err   = 0;
    repeat (3) @(negedge clk_i);
    check_eq("reset.busy", busy_o, 0);
    check_eq("reset.ovr", overrun_o, 0);
    check_eq("reset.err", err_o, 0);
    check_all("reset");
    reset_i = 1'b0;
    repeat (2) @(negedge clk_i);

    // Ack with nothing held is ignored.
    ack_pulse();

    send_frame(8'hA5, DW, 0, 0);
    ack_pulse();

    send_frame(8'h3C, DW, 1, 1);
    send_frame(8'hC3, DW, 1, 0);

    send_frame(8'h11, DW, 0, 1);
    send_frame(8'h22, DW, 0, 0);

    send_frame(8'h5A, 5, 0, 2);
    ack_pulse();
    send_frame(8'h6B, 5, 0, 2);
    send_frame(8'h7E, DW, 0, 0);

    send_frame(8'h81, DW, 0, 1);
    send_frame(8'h42, DW, 2, 0);
    ack_pulse();

    reset_mid_frame(8'hE0);
    send_frame(8'hFF, DW, 0, 0);

    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(9);
      w  = DW'($urandom);
      am = $urandom_range(2);
      if (op < 6) begin
        em = $urandom_range(1);
        send_frame(w, DW, am, em);
      end else if (op < 8) begin
        nb = $urandom_range(DW - 1);
        send_frame(w, nb, 0, 2);
      end else if (op == 8) begin
        if (en_i) send_frame(w, DW, am, 0);
        ack_pulse();
      end else begin
        reset_mid_frame(w);
      end
    end
    if (en_i) send_frame(8'h96, DW, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
